sdram_arb: RTL and testbench
============================

# sdram_arb

Two-port arbiter placed between the shared SDRAM controller and its two requesters: the HPS download path (ROM/background image writes) and the VFD renderer (pixel reads). It replaces the static download-selects-address mux with a sequenced command stream: one command in flight, a one-entry write buffer with `ioctl_wait` back-pressure, and a bounded-starvation priority rule so VFD reads still complete during a long download.

## Interface
Parameters:
- `AW`, 25: address width, both ports and controller side.
- `DW`, 8: data width.
- `STARVE`, 4: maximum number of consecutive writes issued while a read is pending; range 1..15.

Ports:
- `clk` in 1: system clock; the `clk_sys` domain, 100 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `wr_req` in 1: download write strobe (`ioctl_wr`), one-cycle pulse.
- `wr_addr` in AW: write address.
- `wr_data` in DW: write data.
- `wr_wait` out 1: back-pressure to `ioctl_wait`; high while the write buffer is full.
- `rd_req` in 1: VFD read strobe, one-cycle pulse.
- `rd_addr` in AW: read address.
- `rd_data` out DW: read data; held until the next read completes.
- `rd_valid` out 1: one-cycle pulse when `rd_data` is updated.
- `mem_addr` out AW: controller address.
- `mem_din` out DW: controller write data.
- `mem_we` out 1: controller write command, one-cycle pulse.
- `mem_rd` out 1: controller read command, one-cycle pulse.
- `mem_dout` in DW: controller read data.
- `mem_ready` in 1: controller idle. Low no later than 1 cycle after a command pulse; high again on completion. Read data is valid in the first cycle `mem_ready` is high again.
- `err` out 1: sticky protocol-violation flag.

## Operation
- Write slot: registers addr, data and full flag. `wr_req` while not full loads the slot and sets full. `wr_wait` = full.
- Read slot: registers addr and pending flag. `rd_req` while not pending loads the slot.
- Violations: `wr_req` while the write slot is full, or `rd_req` while a read is pending. The strobe is dropped, slot contents are unchanged, and `err` is set. `err` clears only on reset.
- FSM states:
  - IDLE: select a request and issue it.
  - ISSUE: command pulse cycle.
  - GAP: one cycle; `mem_ready` is ignored.
  - WAIT: wait for `mem_ready`.
- IDLE selection:
  - Both slots occupied: the read wins if `starve_cnt == STARVE`, otherwise the write wins.
  - One slot occupied: that slot is served.
  - Neither occupied: stay in IDLE.
- ISSUE:
  - Drives `mem_addr` and `mem_din` from the chosen slot and pulses `mem_we` or `mem_rd`.
  - For a write, the slot is freed in this cycle.
  - Goes to GAP.
- GAP goes to WAIT.
- WAIT:
  - On `mem_ready` = 1 after a read: latch `mem_dout` into `rd_data`, pulse `rd_valid`, clear read pending.
  - On `mem_ready` = 1, always: go to IDLE.
- `starve_cnt` (4 bits):
  - Increments on each write issue while a read is pending.
  - Clears on each read issue and whenever no read is pending.
  - Saturates at STARVE.
- Simultaneous events:
  - A `wr_req` in the same cycle the slot frees (ISSUE of a write) is accepted, not flagged.
  - A `rd_req` in the same cycle `rd_valid` pulses is accepted.
- `mem_addr` and `mem_din` hold their last issued values between commands.

## Timing
- Reset values: `wr_wait`=0, `rd_data`=0, `rd_valid`=0, `mem_addr`=0, `mem_din`=0, `mem_we`=0, `mem_rd`=0, `err`=0. FSM=IDLE, both slots empty, `starve_cnt`=0.
- Request accept to command pulse: 2 cycles with the FSM in IDLE (slot load, then IDLE, then ISSUE).
- Minimum command-to-command spacing: 4 cycles (ISSUE, GAP, WAIT of at least 1 cycle, IDLE).
- `rd_valid` pulses 1 cycle after WAIT samples `mem_ready` high. `rd_data` is stable from that cycle on.
- `wr_wait` rises 1 cycle after an accepted `wr_req`. It falls the cycle after ISSUE of that write.
- Reset asserted mid-operation: all state clears immediately. In-flight and buffered requests are lost; no `rd_valid` is produced for them. The controller is re-initialised separately.

## Structure
- Shared package `sdram_arb_pkg`:
  - FSM state enum (IDLE, ISSUE, GAP, WAIT).
  - Grant enum (GNT_WR, GNT_RD).
  - Default constants AW=25, DW=8, STARVE=4.
- One sub-module, `req_slot`: a parameterised single-entry register with load, free, full flag and overflow-detect output. Instantiated twice (write slot carries data; read slot has DW=0 data unused).
- The top level holds the FSM, grant logic, `starve_cnt` and the output registers.

## Test plan
- Single write: `wr_req` at addr 0x12 with data 0xA5, `mem_ready` idle → `mem_we` pulses 2 cycles later with `mem_addr`=0x12 and `mem_din`=0xA5; `wr_wait` high for exactly 2 cycles.
- Single read: `rd_req` at addr 0x40; controller returns 0x3C with 5-cycle busy → `mem_rd` pulse, then `rd_valid` one cycle with `rd_data`=0x3C; `rd_data` holds 0x3C afterwards.
- Starvation bound: continuous writes honouring `wr_wait`, `rd_req` at addr 0x100 mid-stream, STARVE=4 → exactly 4 writes issue after the read is pending, then `mem_rd` at addr 0x100.
- Violations: second `wr_req` while `wr_wait`=1 → dropped, original slot data issued, `err`=1; `err` still 1 after 100 cycles.
- Same-cycle accept: `wr_req` in the write-ISSUE cycle → accepted, `err`=0, issued as the next write.
- Reset mid-read: `reset` asserted during WAIT → all outputs 0 on the same edge; after release, no `rd_valid` and FSM in IDLE.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and default sizes for the SDRAM two-port arbiter
package sdram_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP, WAIT} state_t;
    typedef enum logic {GNT_WR, GNT_RD} gnt_t;
    localparam int AW_DEF = 25;
    localparam int DW_DEF = 8;
    localparam int STARVE_DEF = 4;
endpackage

// File: rtl/sdram_arb_slot.sv
// req_slot: single-entry request register; refills in its free cycle, flags overflow
module req_slot #(
    parameter int AW = 25,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             free,
    input  logic [AW+DW-1:0] d,
    output logic [AW+DW-1:0] q,
    output logic             full,
    output logic             ovf
);
    assign ovf = load && full && !free;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            q    <= '0;
        end else if (load && !ovf) begin
            full <= 1'b1;
            q    <= d;
        end else if (free) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/sdram_arb.sv
// sdram_arb: sequences download writes and VFD reads onto the shared SDRAM controller,
// one command in flight, with a bounded number of writes allowed ahead of a pending read.
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int STARVE = STARVE_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_wait,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_ready,
    output logic          err
);
    state_t state;
    gnt_t gnt, pick;
    logic [3:0] starve_cnt;
    logic [AW+DW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic wr_full, rd_full, wr_ovf, rd_ovf, wr_free, rd_free;

    assign wr_free = state == ISSUE && gnt == GNT_WR;
    assign rd_free = state == WAIT && mem_ready && gnt == GNT_RD;
    assign pick    = (rd_full && (!wr_full || starve_cnt == 4'(STARVE))) ? GNT_RD : GNT_WR;
    assign wr_wait = wr_full;

    req_slot #(.AW(AW), .DW(DW)) u_wr (
        .clk(clk), .reset(reset), .load(wr_req), .free(wr_free),
        .d({wr_addr, wr_data}), .q(wr_q), .full(wr_full), .ovf(wr_ovf)
    );

    req_slot #(.AW(AW), .DW(0)) u_rd (
        .clk(clk), .reset(reset), .load(rd_req), .free(rd_free),
        .d(rd_addr), .q(rd_q), .full(rd_full), .ovf(rd_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= GNT_WR;
            starve_cnt <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_we     <= 1'b0;
            mem_rd     <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            mem_rd   <= 1'b0;
            rd_valid <= 1'b0;
            err      <= err | wr_ovf | rd_ovf;
            if (!rd_full)
                starve_cnt <= '0;
            case (state)
                IDLE: if (wr_full || rd_full) begin
                    state <= ISSUE;
                    gnt   <= pick;
                    if (pick == GNT_RD) begin
                        mem_rd     <= 1'b1;
                        mem_addr   <= rd_q;
                        starve_cnt <= '0;
                    end else begin
                        mem_we              <= 1'b1;
                        {mem_addr, mem_din} <= wr_q;
                        if (rd_full && starve_cnt != 4'(STARVE))
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                ISSUE: state <= GAP;
                // the controller may still report ready here, so it is not sampled
                GAP: state <= WAIT;
                WAIT: if (mem_ready) begin
                    state <= IDLE;
                    if (gnt == GNT_RD) begin
                        rd_data  <= mem_dout;
                        rd_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: directed scenarios plus randomized traffic against a transaction-timing model
module tb_sdram_arb;
    localparam int AW = 25, DW = 8, STARVE = 4;

    logic clk = 1'b0, reset = 1'b1;
    logic wr_req = 1'b0, rd_req = 1'b0, mem_ready = 1'b1;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0, mem_dout = '0;
    logic wr_wait, rd_valid, mem_we, mem_rd, err;
    logic [DW-1:0] rd_data, mem_din;
    logic [AW-1:0] mem_addr;

    int checks = 0, fails = 0;
    bit chk_on = 1'b0;
    int busy = 0, force_n = 0, force_d = -1;

    bit m_wr_occ, m_rd_occ, m_fly, m_fly_rd, m_we, m_rd, m_rv, m_err;
    logic [AW-1:0] m_wr_a, m_rd_a, m_addr;
    logic [DW-1:0] m_wr_d, m_din, m_rdata;
    int m_starve, m_cyc, m_issue_at;

    always #5 clk = ~clk;

    sdram_arb #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_wait(wr_wait),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .mem_ready(mem_ready), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        {m_wr_occ, m_rd_occ, m_fly, m_fly_rd, m_we, m_rd, m_rv, m_err} = '0;
        m_wr_a = '0; m_rd_a = '0; m_addr = '0;
        m_wr_d = '0; m_din = '0; m_rdata = '0;
        m_starve = 0; m_cyc = 0; m_issue_at = 0;
    endtask

    // Advances the model from cycle m_cyc to the next, using the inputs held during m_cyc.
    // A command pulses the cycle after arbitration, and completes at the first ready cycle
    // at least two cycles after its pulse.
    task automatic model_update();
        bit idle, wfree, rfree, done, gw, gr;
        if (reset) begin
            model_reset();
            return;
        end
        idle  = !m_fly;
        done  = m_fly && m_cyc >= m_issue_at + 2 && mem_ready;
        wfree = m_we;
        rfree = done && m_fly_rd;
        gr = idle && m_rd_occ && (!m_wr_occ || m_starve == STARVE);
        gw = idle && m_wr_occ && !gr;
        m_we = gw;
        m_rd = gr;
        m_rv = 1'b0;
        if (done) begin
            m_fly = 1'b0;
            if (m_fly_rd) begin
                m_rv = 1'b1;
                m_rdata = mem_dout;
            end
        end
        if (!m_rd_occ || gr) m_starve = 0;
        else if (gw) m_starve++;
        if (gw || gr) begin
            m_fly = 1'b1;
            m_fly_rd = gr;
            m_issue_at = m_cyc + 1;
            m_addr = gr ? m_rd_a : m_wr_a;
            if (gw) m_din = m_wr_d;
        end
        if (wr_req && m_wr_occ && !wfree) m_err = 1'b1;
        else if (wr_req) begin m_wr_occ = 1'b1; m_wr_a = wr_addr; m_wr_d = wr_data; end
        else if (wfree) m_wr_occ = 1'b0;
        if (rd_req && m_rd_occ && !rfree) m_err = 1'b1;
        else if (rd_req) begin m_rd_occ = 1'b1; m_rd_a = rd_addr; end
        else if (rfree) m_rd_occ = 1'b0;
        m_cyc++;
    endtask

    // Controller stand-in: busy for N cycles starting with the command pulse cycle.
    task automatic ctrl();
        if (reset) begin
            mem_ready = 1'b1;
            busy = 0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                mem_ready = 1'b1;
                mem_dout = force_d >= 0 ? DW'(force_d) : DW'($urandom);
            end
        end else if (mem_we || mem_rd) begin
            mem_ready = 1'b0;
            busy = force_n > 0 ? force_n : $urandom_range(1, 5);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        ctrl();
    endtask

    always @(negedge clk) if (chk_on) begin
        chk("wr_wait", wr_wait, m_wr_occ);
        chk("mem_we", mem_we, m_we);
        chk("mem_rd", mem_rd, m_rd);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_din", mem_din, m_din);
        chk("rd_valid", rd_valid, m_rv);
        chk("rd_data", rd_data, m_rdata);
        chk("err", err, m_err);
    end

    initial begin
        int t_rd, t_rv, nw, a;
        bit seen, bad;
        model_reset();
        repeat (3) step();
        chk("reset_state", {wr_wait, rd_valid, mem_we, mem_rd, err, rd_data, mem_din, mem_addr}, 64'd0);
        reset = 1'b0;
        chk_on = 1'b1;
        repeat (2) step();

        wr_req = 1'b1; wr_addr = AW'('h12); wr_data = 8'hA5;
        step();
        chk("w_wait_rise", wr_wait, 1);
        chk("w_we_early", mem_we, 0);
        step();
        chk("w_we", mem_we, 1);
        chk("w_addr", mem_addr, 'h12);
        chk("w_din", mem_din, 'hA5);
        chk("w_wait_hold", wr_wait, 1);
        step();
        chk("w_wait_fall", wr_wait, 0);
        chk("w_we_pulse", mem_we, 0);
        repeat (10) step();

        force_n = 5; force_d = 'h3C;
        rd_req = 1'b1; rd_addr = AW'('h40);
        t_rd = 0; t_rv = 0;
        for (int n = 1; n <= 20 && t_rv == 0; n++) begin
            step();
            if (mem_rd) begin t_rd = n; chk("r_addr", mem_addr, 'h40); end
            if (rd_valid) begin t_rv = n; chk("r_data", rd_data, 'h3C); end
        end
        chk("r_issue_lat", t_rd, 2);
        chk("r_valid_lat", t_rv, 8);
        step();
        chk("r_valid_pulse", rd_valid, 0);
        chk("r_data_hold", rd_data, 'h3C);
        repeat (5) step();

        rd_req = 1'b1; rd_addr = AW'('h55);
        step();
        wr_req = 1'b1; wr_addr = AW'('h66); wr_data = 8'h77;
        repeat (4) step();
        chk("rr_pre_addr", mem_addr, 'h55);
        chk("rr_pre_wait", wr_wait, 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rr_outputs", {wr_wait, rd_valid, mem_we, mem_rd, err, rd_data, mem_din, mem_addr}, 64'd0);
        force_n = 0; force_d = -1;
        repeat (2) step();
        reset = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            step();
            if (rd_valid || mem_rd || mem_we) bad = 1'b1;
        end
        chk("rr_quiet", bad, 0);

        nw = 0; seen = 1'b0; a = 'h200;
        for (int n = 0; n < 300 && !seen; n++) begin
            step();
            if (n >= 22 && mem_we) nw++;
            if (mem_rd) begin seen = 1'b1; chk("s_rd_addr", mem_addr, 'h100); end
            if (!wr_wait) begin wr_req = 1'b1; wr_addr = AW'(a); wr_data = DW'(a); a++; end
            if (n == 20) begin rd_req = 1'b1; rd_addr = AW'('h100); end
        end
        chk("s_rd_seen", seen, 1);
        chk("s_writes", nw, STARVE);
        repeat (30) step();

        wr_req = 1'b1; wr_addr = AW'('h20); wr_data = 8'h11;
        step();
        chk("v_wait", wr_wait, 1);
        wr_req = 1'b1; wr_addr = AW'('h21); wr_data = 8'h22;
        step();
        chk("v_we", mem_we, 1);
        chk("v_addr", mem_addr, 'h20);
        chk("v_din", mem_din, 'h11);
        chk("v_err", err, 1);
        repeat (100) step();
        chk("v_err_sticky", err, 1);
        reset = 1'b1;
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        repeat (2) step();

        wr_req = 1'b1; wr_addr = AW'('h30); wr_data = 8'h01;
        repeat (2) step();
        chk("sc_we1", mem_we, 1);
        wr_req = 1'b1; wr_addr = AW'('h31); wr_data = 8'h02;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (mem_we) begin
                seen = 1'b1;
                chk("sc_addr", mem_addr, 'h31);
                chk("sc_din", mem_din, 'h02);
            end
        end
        chk("sc_seen", seen, 1);
        chk("sc_err", err, 0);

        for (int n = 0; n < 1500; n++) begin
            step();
            if ((!wr_wait && $urandom_range(0, 1) == 1) || $urandom_range(0, 99) == 0) begin
                wr_req = 1'b1; wr_addr = AW'($urandom); wr_data = DW'($urandom);
            end
            if ((!m_rd_occ && $urandom_range(0, 4) == 0) || (!mem_ready && $urandom_range(0, 199) == 0)) begin
                rd_req = 1'b1; rd_addr = AW'($urandom);
            end
        end
        repeat (20) step();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
